reset_sequencer: RTL and testbench
==================================

# reset_sequencer

Power-up and push-button reset controller that releases a chain of downstream reset domains in a fixed order. It replaces the single delayed reset with per-stage releases. Each stage is released only after the previous stage reports Ready, with a fixed gap between stages and a per-stage timeout. The block sits at the top level between the board reset button and every sub-block reset input.

## Interface
- STAGES, 4: number of sequenced reset domains (2..8).
- DELAY_W, 23: power-up counter width; the power-up hold lasts 2^DELAY_W cycles.
- GAP_CYCLES, 16: idle cycles between a stage's Ready and release of the next stage (≥1).
- TIMEOUT_W, 16: per-stage Ready timeout; the timeout is 2^TIMEOUT_W cycles.

Ports:
- Clk  in  1  system clock; everything is synchronous to the rising edge.
- nReset  in  1  asynchronous, active-low reset. Assertion is immediate; deassertion is sampled on Clk.
- Button  in  1  external reset button, asynchronous, active-high.
- Ready  in  STAGES  per-stage ready/alive flag, synchronous to Clk.
- StageReset  out  STAGES  per-stage active-high reset; bit i drives domain i.
- Done  out  1  high while all stages are released and healthy.
- Fault  out  1  sticky fault flag.
- FaultStage  out  $clog2(STAGES)  index of the faulting stage.

## Operation
- **nReset low:**
  - StageReset = all ones; Done = 0; Fault = 0; FaultStage = 0.
  - State = HOLD; all counters = 0; stage index = 0.
  - Button synchroniser flops = 1, so the block treats Button as pressed.
- **Button synchroniser:** two flops. Bsync is the second flop. All Button references below mean Bsync.
- **Bsync = 1 in any state:**
  - State goes to HOLD; StageReset = all ones; Done = 0; Fault = 0; counters cleared.
  - Bsync has priority over every other event.
- **HOLD:** when Bsync = 0, go to POWERUP with count = 0.
- **POWERUP:**
  - Count increments each cycle.
  - On the edge where count is all ones: clear StageReset[0], set idx = 0, timer = 0, enter WAIT_READY.
- **WAIT_READY:** sample Ready[idx] each edge.
  - Ready[idx] = 1 and idx < STAGES-1: enter GAP with gap count = 0.
  - Ready[idx] = 1 and idx = STAGES-1: enter RUN and set Done = 1.
  - Ready[idx] = 0 and timer all ones: enter FAULT.
  - Otherwise: timer increments.
  - Ready wins over timeout in the same cycle.
  - At least one cycle is always spent in WAIT_READY, even when Ready is already high.
- **GAP:**
  - Gap count increments.
  - On the edge where gap count = GAP_CYCLES-1: idx increments, StageReset[idx] is cleared, timer = 0, enter WAIT_READY.
- **RUN:**
  - Done = 1.
  - If Ready[i] = 0 for any i, enter FAULT with FaultStage = lowest such i.
- **FAULT entry (same edge):**
  - StageReset = all ones; Done = 0; Fault = 1.
  - FaultStage = idx when entered from WAIT_READY, or the lowest dropped index when entered from RUN.
- **FAULT:** stays until Bsync = 1 (then HOLD) or nReset.
- **Reset bit monotonicity:** StageReset bits only deassert in ascending index order. Reassertion is always all bits together.
- **Counter rules:** counters never wrap. Each terminal count is consumed by the state transition.

## Timing
- All outputs are registered; no combinational path from input to output.
- Button press to StageReset all ones: 3 edges (2 synchroniser edges + 1 state edge), unless the block is already in HOLD.
- **Release schedule**, with E0 = the edge leaving HOLD for POWERUP:
  - StageReset[0] falls at E0 + 2^DELAY_W.
  - With Ready already high, StageReset[i+1] falls 1 + GAP_CYCLES edges after StageReset[i].
  - Done rises 1 edge after StageReset[STAGES-1] falls.
- **Timeout:** if Ready[idx] never rises, FAULT is entered 2^TIMEOUT_W edges after StageReset[idx] falls.
- **RUN drop:** Ready drop in RUN to Fault = 1 edge.
- **Mid-operation reset:** nReset assertion mid-sequence forces reset values asynchronously; no clock is needed.

## Test plan
Parameters for all scenarios: STAGES=4, DELAY_W=4, GAP_CYCLES=3, TIMEOUT_W=5.

1. Release nReset, Button = 0, Ready = 4'b1111 → StageReset = 1111 until E0+16, then bits fall at 4-cycle spacing (0111 is never seen; order is 1110, 1100, 1000, 0000); Done = 1 one cycle after 0000; Fault = 0.
2. Ready[2] held 0, others 1 → 32 cycles after StageReset[2] falls: StageReset = 1111, Fault = 1, FaultStage = 2, Done = 0; state persists until Button pulses.
3. Reach RUN, then drop Ready[1] and Ready[3] in the same cycle → next edge: Fault = 1, FaultStage = 1, StageReset = 1111, Done = 0.
4. Button pulsed for 5 cycles mid-POWERUP → StageReset stays 1111, Fault clears. Sequence restarts, and StageReset[0] falls 16 cycles after the new E0.
5. nReset pulsed low between clock edges while in GAP with StageReset = 1100 → StageReset = 1111 and Done = 0 immediately. Sequence restarts only after the synchroniser sees Button low.
6. Ready[0] rises exactly on the edge where the timer is all ones → no fault; GAP is entered; StageReset[1] falls 3 cycles later.

Source files
------------

// File: rtl/reset_sequencer.sv
// Reset sequencer: holds every downstream domain in reset after power-up or a button
// press, then releases the domains one at a time, each gated on the previous stage's Ready.
//
// state        | meaning
// S_HOLD       | button seen pressed; all domains held in reset
// S_POWERUP    | power-up hold, counting 2^DELAY_W cycles
// S_WAIT_READY | stage idx released, waiting for Ready[idx] or timeout
// S_GAP        | idle gap before releasing stage idx+1
// S_RUN        | all stages released and healthy
// S_FAULT      | timeout or Ready drop; all domains held until the button

module reset_sequencer #(
    parameter int  STAGES     = 4,
    parameter int  DELAY_W    = 23,
    parameter int  GAP_CYCLES = 16,
    parameter int  TIMEOUT_W  = 16,
    localparam int IDX_W      = (STAGES > 1) ? $clog2(STAGES) : 1
) (
    input  logic              Clk,
    input  logic              nReset,
    input  logic              Button,
    input  logic [STAGES-1:0] Ready,
    output logic [STAGES-1:0] StageReset,
    output logic              Done,
    output logic              Fault,
    output logic [IDX_W-1:0]  FaultStage
);

    localparam int               GAP_W    = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(STAGES - 1);
    localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'(GAP_CYCLES - 1);

    typedef enum logic [2:0] {
        S_HOLD,
        S_POWERUP,
        S_WAIT_READY,
        S_GAP,
        S_RUN,
        S_FAULT
    } state_e;

    state_e               state_q, state_d;
    logic                 btn_meta_q, btn_sync_q;
    logic [DELAY_W-1:0]   pwr_cnt_q, pwr_cnt_d;
    logic [TIMEOUT_W-1:0] timer_q, timer_d;
    logic [GAP_W-1:0]     gap_cnt_q, gap_cnt_d;
    logic [IDX_W-1:0]     idx_q, idx_d;
    logic [STAGES-1:0]    stage_reset_q, stage_reset_d;
    logic                 done_q, done_d;
    logic                 fault_q, fault_d;
    logic [IDX_W-1:0]     fault_stage_q, fault_stage_d;
    logic [IDX_W-1:0]     low_drop;

    // Synchroniser resets to "pressed" so nothing is released before Button is seen low.
    always_ff @(posedge Clk or negedge nReset) begin
        if (!nReset) begin
            btn_meta_q <= 1'b1;
            btn_sync_q <= 1'b1;
        end else begin
            btn_meta_q <= Button;
            btn_sync_q <= btn_meta_q;
        end
    end

    always_comb begin
        low_drop = '0;
        for (int i = STAGES - 1; i >= 0; i--) begin
            if (!Ready[i]) begin
                low_drop = IDX_W'(i);
            end
        end
    end

    always_comb begin
        state_d       = state_q;
        pwr_cnt_d     = pwr_cnt_q;
        timer_d       = timer_q;
        gap_cnt_d     = gap_cnt_q;
        idx_d         = idx_q;
        stage_reset_d = stage_reset_q;
        done_d        = done_q;
        fault_d       = fault_q;
        fault_stage_d = fault_stage_q;

        if (btn_sync_q) begin
            state_d       = S_HOLD;
            pwr_cnt_d     = '0;
            timer_d       = '0;
            gap_cnt_d     = '0;
            idx_d         = '0;
            stage_reset_d = '1;
            done_d        = 1'b0;
            fault_d       = 1'b0;
            fault_stage_d = '0;
        end else begin
            case (state_q)
                S_HOLD: begin
                    state_d   = S_POWERUP;
                    pwr_cnt_d = '0;
                end
                S_POWERUP: begin
                    if (pwr_cnt_q == '1) begin
                        state_d          = S_WAIT_READY;
                        pwr_cnt_d        = '0;
                        idx_d            = '0;
                        timer_d          = '0;
                        stage_reset_d[0] = 1'b0;
                    end else begin
                        pwr_cnt_d = pwr_cnt_q + DELAY_W'(1);
                    end
                end
                S_WAIT_READY: begin
                    // Ready is checked before the timeout so a same-cycle arrival still counts.
                    if (Ready[idx_q]) begin
                        timer_d = '0;
                        if (idx_q == LAST_IDX) begin
                            state_d = S_RUN;
                            done_d  = 1'b1;
                        end else begin
                            state_d   = S_GAP;
                            gap_cnt_d = '0;
                        end
                    end else if (timer_q == '1) begin
                        state_d       = S_FAULT;
                        timer_d       = '0;
                        stage_reset_d = '1;
                        done_d        = 1'b0;
                        fault_d       = 1'b1;
                        fault_stage_d = idx_q;
                    end else begin
                        timer_d = timer_q + TIMEOUT_W'(1);
                    end
                end
                S_GAP: begin
                    if (gap_cnt_q == GAP_LAST) begin
                        state_d              = S_WAIT_READY;
                        gap_cnt_d            = '0;
                        timer_d              = '0;
                        idx_d                = idx_q + IDX_W'(1);
                        stage_reset_d[idx_d] = 1'b0;
                    end else begin
                        gap_cnt_d = gap_cnt_q + GAP_W'(1);
                    end
                end
                S_RUN: begin
                    done_d = 1'b1;
                    if (!(&Ready)) begin
                        state_d       = S_FAULT;
                        stage_reset_d = '1;
                        done_d        = 1'b0;
                        fault_d       = 1'b1;
                        fault_stage_d = low_drop;
                    end
                end
                S_FAULT: begin
                    stage_reset_d = '1;
                    done_d        = 1'b0;
                    fault_d       = 1'b1;
                end
                default: begin
                    state_d       = S_HOLD;
                    stage_reset_d = '1;
                    done_d        = 1'b0;
                end
            endcase
        end
    end

    always_ff @(posedge Clk or negedge nReset) begin
        if (!nReset) begin
            state_q       <= S_HOLD;
            pwr_cnt_q     <= '0;
            timer_q       <= '0;
            gap_cnt_q     <= '0;
            idx_q         <= '0;
            stage_reset_q <= '1;
            done_q        <= 1'b0;
            fault_q       <= 1'b0;
            fault_stage_q <= '0;
        end else begin
            state_q       <= state_d;
            pwr_cnt_q     <= pwr_cnt_d;
            timer_q       <= timer_d;
            gap_cnt_q     <= gap_cnt_d;
            idx_q         <= idx_d;
            stage_reset_q <= stage_reset_d;
            done_q        <= done_d;
            fault_q       <= fault_d;
            fault_stage_q <= fault_stage_d;
        end
    end

    assign StageReset = stage_reset_q;
    assign Done       = done_q;
    assign Fault      = fault_q;
    assign FaultStage = fault_stage_q;

endmodule

// File: tb/tb_reset_sequencer.sv
// Bench for reset_sequencer: a release-schedule model (edge arithmetic per stage) predicts
// every output each cycle while Ready delays, button presses and drops are randomised.

module tb_reset_sequencer;

    localparam int ST    = 4;
    localparam int DW    = 4;
    localparam int GAPC  = 3;
    localparam int TW    = 5;
    localparam int INF   = 1 << 28;
    localparam int NEVER = 1000;

    logic          Clk = 1'b0;
    logic          nReset;
    logic          Button;
    logic [ST-1:0] Ready;
    logic [ST-1:0] StageReset;
    logic          Done;
    logic          Fault;
    logic [1:0]    FaultStage;

    int            total = 0;
    int            bad   = 0;
    int            cyc   = 0;
    int            d    [ST];
    int            fall [ST];
    int            done_edge, flt_edge, flt_stage, hold_edge, drop_from;
    logic [ST-1:0] drop_mask;
    logic [7:0]    e;

    reset_sequencer #(
        .STAGES    (ST),
        .DELAY_W   (DW),
        .GAP_CYCLES(GAPC),
        .TIMEOUT_W (TW)
    ) dut (
        .Clk       (Clk),
        .nReset    (nReset),
        .Button    (Button),
        .Ready     (Ready),
        .StageReset(StageReset),
        .Done      (Done),
        .Fault     (Fault),
        .FaultStage(FaultStage)
    );

    always #5 Clk = ~Clk;
    always @(posedge Clk) cyc <= cyc + 1;

    // Schedule from the edge leaving HOLD: each stage is accepted max(d,1) edges after its
    // release, the next release follows GAPC edges later, and d beyond 2^TW means timeout.
    function automatic void plan(int e0);
        int acc;
        hold_edge = INF; flt_edge = INF; flt_stage = 0; done_edge = INF;
        drop_mask = '0; drop_from = INF;
        for (int i = 0; i < ST; i++) fall[i] = INF;
        fall[0] = e0 + (1 << DW);
        for (int i = 0; i < ST; i++) begin
            if (d[i] > (1 << TW)) begin
                flt_edge  = fall[i] + (1 << TW);
                flt_stage = i;
                break;
            end
            acc = fall[i] + ((d[i] == 0) ? 1 : d[i]);
            if (i == ST - 1) done_edge = acc;
            else fall[i+1] = acc + GAPC;
        end
    endfunction

    // Expected {StageReset, Done, Fault, FaultStage} after edge k.
    function automatic logic [7:0] model(int k);
        logic [3:0] sr;
        if (k >= hold_edge) return 8'hF0;
        if (k >= flt_edge) return {4'hF, 1'b0, 1'b1, 2'(flt_stage)};
        sr = 4'hF;
        for (int i = 0; i < ST; i++) if (k >= fall[i]) sr[i] = 1'b0;
        return {sr, (k >= done_edge), 1'b0, 2'b00};
    endfunction

    // Ready value presented for edge k+1.
    function automatic logic [ST-1:0] ready_for(int k);
        logic [ST-1:0] r;
        for (int i = 0; i < ST; i++)
            r[i] = ((d[i] == 0) || (k + 1 >= fall[i] + d[i])) && !(drop_mask[i] && k >= drop_from);
        return r;
    endfunction

    function automatic int pick_delay();
        case ($urandom_range(0, 9))
            0: return 31;
            1: return 32;
            2: return 33;
            3: return NEVER;
            default: return int'($urandom_range(0, 5));
        endcase
    endfunction

    task automatic step();
        @(negedge Clk);
        Ready = ready_for(cyc);
    endtask

    task automatic btn_down();
        Button    = 1'b1;
        hold_edge = cyc + 3;
    endtask

    task automatic btn_up();
        Button = 1'b0;
        plan(cyc + 3);
        Ready = ready_for(cyc);
    endtask

    task automatic test_reset();
        nReset = 1'b0; Button = 1'b0; Ready = '0;
        for (int i = 0; i < ST; i++) d[i] = 0;
        plan(INF / 2);
        repeat (3) begin
            step();
            total++;
            if ({StageReset, Done, Fault, FaultStage} !== 8'hF0) begin
                bad++;
                $display("FAIL reset_state cyc=%0d got=%b want=%b", cyc, {StageReset, Done, Fault, FaultStage}, 8'hF0);
            end
        end
    endtask

    task automatic test_release();
        logic [3:0] seen[$];
        logic [3:0] want[5];
        int         c0;
        want   = '{4'hF, 4'hE, 4'hC, 4'h8, 4'h0};
        nReset = 1'b1;
        plan(cyc + 3);
        Ready = ready_for(cyc);
        c0 = cyc;
        while (cyc < c0 + 45) begin
            step();
            e = model(cyc);
            total++;
            if ({StageReset, Done, Fault, FaultStage} !== e) begin
                bad++;
                $display("FAIL release cyc=%0d got=%b want=%b", cyc, {StageReset, Done, Fault, FaultStage}, e);
            end
            if (seen.size() == 0 || seen[seen.size()-1] !== StageReset) seen.push_back(StageReset);
        end
        total++;
        if (seen.size() != 5) begin
            bad++;
            $display("FAIL release_order_len got=%0d want=5", seen.size());
        end else begin
            for (int i = 0; i < 5; i++) begin
                total++;
                if (seen[i] !== want[i]) begin
                    bad++;
                    $display("FAIL release_order[%0d] got=%b want=%b", i, seen[i], want[i]);
                end
            end
        end
    endtask

    task automatic test_timeout();
        int obs_fall = -1000;
        int obs_flt  = -1000;
        int target;
        btn_down();
        repeat (2) begin
            step(); e = model(cyc); total++;
            if ({StageReset, Done, Fault, FaultStage} !== e) begin
                bad++;
                $display("FAIL timeout_press cyc=%0d got=%b want=%b", cyc, {StageReset, Done, Fault, FaultStage}, e);
            end
        end
        for (int i = 0; i < ST; i++) d[i] = int'($urandom_range(0, 4));
        d[2] = NEVER;
        btn_up();
        target = flt_edge + 20;
        while (cyc < target) begin
            step(); e = model(cyc); total++;
            if ({StageReset, Done, Fault, FaultStage} !== e) begin
                bad++;
                $display("FAIL timeout cyc=%0d got=%b want=%b", cyc, {StageReset, Done, Fault, FaultStage}, e);
            end
            if (obs_fall < 0 && StageReset[2] === 1'b0) obs_fall = cyc;
            if (obs_flt < 0 && Fault === 1'b1) obs_flt = cyc;
        end
        total++;
        if (obs_flt - obs_fall != 32) begin
            bad++;
            $display("FAIL timeout_latency got=%0d want=32", obs_flt - obs_fall);
        end
        total++;
        if (FaultStage !== 2'd2) begin
            bad++;
            $display("FAIL timeout_stage got=%0d want=2", FaultStage);
        end
    endtask

    task automatic test_run_drop();
        int         target;
        logic [3:0] m;
        for (int rep = 0; rep < 3; rep++) begin
            btn_down();
            repeat (2) begin
                step(); e = model(cyc); total++;
                if ({StageReset, Done, Fault, FaultStage} !== e) begin
                    bad++;
                    $display("FAIL drop_press cyc=%0d got=%b want=%b", cyc, {StageReset, Done, Fault, FaultStage}, e);
                end
            end
            for (int i = 0; i < ST; i++) d[i] = int'($urandom_range(0, 3));
            btn_up();
            target = done_edge + int'($urandom_range(1, 6));
            while (cyc < target) begin
                step(); e = model(cyc); total++;
                if ({StageReset, Done, Fault, FaultStage} !== e) begin
                    bad++;
                    $display("FAIL drop_seq cyc=%0d got=%b want=%b", cyc, {StageReset, Done, Fault, FaultStage}, e);
                end
            end
            m = (rep == 0) ? 4'b1010 : 4'($urandom_range(1, 15));
            drop_mask = m; drop_from = cyc; flt_edge = cyc + 1;
            for (int i = ST - 1; i >= 0; i--) if (m[i]) flt_stage = i;
            Ready = ready_for(cyc);
            repeat (6) begin
                step(); e = model(cyc); total++;
                if ({StageReset, Done, Fault, FaultStage} !== e) begin
                    bad++;
                    $display("FAIL drop mask=%b cyc=%0d got=%b want=%b", m, cyc, {StageReset, Done, Fault, FaultStage}, e);
                end
            end
        end
    endtask

    task automatic test_button_powerup();
        int e0n;
        int target;
        int obs = -1000;
        btn_down();
        repeat (3) begin
            step(); e = model(cyc); total++;
            if ({StageReset, Done, Fault, FaultStage} !== e) begin
                bad++;
                $display("FAIL btn_clear cyc=%0d got=%b want=%b", cyc, {StageReset, Done, Fault, FaultStage}, e);
            end
        end
        for (int i = 0; i < ST; i++) d[i] = 0;
        btn_up();
        target = cyc + 3 + int'($urandom_range(1, 12));
        while (cyc < target) begin
            step(); e = model(cyc); total++;
            if ({StageReset, Done, Fault, FaultStage} !== e) begin
                bad++;
                $display("FAIL btn_powerup cyc=%0d got=%b want=%b", cyc, {StageReset, Done, Fault, FaultStage}, e);
            end
        end
        btn_down();
        repeat (5) begin
            step(); e = model(cyc); total++;
            if ({StageReset, Done, Fault, FaultStage} !== e) begin
                bad++;
                $display("FAIL btn_midpress cyc=%0d got=%b want=%b", cyc, {StageReset, Done, Fault, FaultStage}, e);
            end
        end
        btn_up();
        e0n    = cyc + 3;
        target = done_edge + 4;
        while (cyc < target) begin
            step(); e = model(cyc); total++;
            if ({StageReset, Done, Fault, FaultStage} !== e) begin
                bad++;
                $display("FAIL btn_restart cyc=%0d got=%b want=%b", cyc, {StageReset, Done, Fault, FaultStage}, e);
            end
            if (obs < 0 && StageReset[0] === 1'b0) obs = cyc;
        end
        total++;
        if (obs - e0n != 16) begin
            bad++;
            $display("FAIL btn_restart_delay got=%0d want=16", obs - e0n);
        end
    endtask

    task automatic test_async_reset();
        int target;
        btn_down();
        repeat (2) begin
            step(); e = model(cyc); total++;
            if ({StageReset, Done, Fault, FaultStage} !== e) begin
                bad++;
                $display("FAIL async_press cyc=%0d got=%b want=%b", cyc, {StageReset, Done, Fault, FaultStage}, e);
            end
        end
        for (int i = 0; i < ST; i++) d[i] = int'($urandom_range(1, 4));
        btn_up();
        target = fall[2] - 2;
        while (cyc < target) begin
            step(); e = model(cyc); total++;
            if ({StageReset, Done, Fault, FaultStage} !== e) begin
                bad++;
                $display("FAIL async_seq cyc=%0d got=%b want=%b", cyc, {StageReset, Done, Fault, FaultStage}, e);
            end
        end
        total++;
        if (StageReset !== 4'b1100) begin
            bad++;
            $display("FAIL async_in_gap got=%b want=1100", StageReset);
        end
        #1 nReset = 1'b0;
        #1;
        total++;
        if ({StageReset, Done, Fault, FaultStage} !== 8'hF0) begin
            bad++;
            $display("FAIL async_immediate got=%b want=%b", {StageReset, Done, Fault, FaultStage}, 8'hF0);
        end
        #1 nReset = 1'b1;
        plan(cyc + 3);
        Ready  = ready_for(cyc);
        target = done_edge + 4;
        while (cyc < target) begin
            step(); e = model(cyc); total++;
            if ({StageReset, Done, Fault, FaultStage} !== e) begin
                bad++;
                $display("FAIL async_restart cyc=%0d got=%b want=%b", cyc, {StageReset, Done, Fault, FaultStage}, e);
            end
        end
    endtask

    task automatic test_ready_boundary();
        int target;
        int obs0;
        int obs1;
        for (int pass = 0; pass < 2; pass++) begin
            obs0 = -1000; obs1 = -1000;
            btn_down();
            repeat (2) begin
                step(); e = model(cyc); total++;
                if ({StageReset, Done, Fault, FaultStage} !== e) begin
                    bad++;
                    $display("FAIL bound_press cyc=%0d got=%b want=%b", cyc, {StageReset, Done, Fault, FaultStage}, e);
                end
            end
            for (int i = 0; i < ST; i++) d[i] = 0;
            if (pass == 0) d[0] = 32;
            else d[1] = 33;
            btn_up();
            target = ((flt_edge < done_edge) ? flt_edge : done_edge) + 4;
            while (cyc < target) begin
                step(); e = model(cyc); total++;
                if ({StageReset, Done, Fault, FaultStage} !== e) begin
                    bad++;
                    $display("FAIL bound pass=%0d cyc=%0d got=%b want=%b", pass, cyc, {StageReset, Done, Fault, FaultStage}, e);
                end
                if (obs0 < 0 && StageReset[0] === 1'b0) obs0 = cyc;
                if (obs1 < 0 && StageReset[1] === 1'b0) obs1 = cyc;
            end
            if (pass == 0) begin
                total++;
                if (obs1 - obs0 != 35) begin
                    bad++;
                    $display("FAIL bound_ready_wins got=%0d want=35", obs1 - obs0);
                end
            end
        end
    endtask

    task automatic test_back_to_back();
        int target;
        int end_e;
        for (int it = 0; it < 12; it++) begin
            btn_down();
            repeat (int'($urandom_range(2, 4))) begin
                step(); e = model(cyc); total++;
                if ({StageReset, Done, Fault, FaultStage} !== e) begin
                    bad++;
                    $display("FAIL b2b_press it=%0d cyc=%0d got=%b want=%b", it, cyc, {StageReset, Done, Fault, FaultStage}, e);
                end
            end
            for (int i = 0; i < ST; i++) d[i] = pick_delay();
            btn_up();
            end_e = (flt_edge < done_edge) ? flt_edge : done_edge;
            if ($urandom_range(0, 2) == 0) target = cyc + int'($urandom_range(3, 60));
            else target = end_e + int'($urandom_range(1, 5));
            while (cyc < target) begin
                step(); e = model(cyc); total++;
                if ({StageReset, Done, Fault, FaultStage} !== e) begin
                    bad++;
                    $display("FAIL b2b it=%0d cyc=%0d got=%b want=%b", it, cyc, {StageReset, Done, Fault, FaultStage}, e);
                end
            end
            if (flt_edge == INF && cyc >= done_edge && $urandom_range(0, 1) == 1) begin
                drop_mask = 4'($urandom_range(1, 15));
                drop_from = cyc;
                flt_edge  = cyc + 1;
                for (int i = ST - 1; i >= 0; i--) if (drop_mask[i]) flt_stage = i;
                Ready = ready_for(cyc);
                repeat (4) begin
                    step(); e = model(cyc); total++;
                    if ({StageReset, Done, Fault, FaultStage} !== e) begin
                        bad++;
                        $display("FAIL b2b_drop it=%0d cyc=%0d got=%b want=%b", it, cyc, {StageReset, Done, Fault, FaultStage}, e);
                    end
                end
            end
        end
    endtask

    initial begin
        test_reset();
        test_release();
        test_timeout();
        test_run_drop();
        test_button_powerup();
        test_async_reset();
        test_ready_boundary();
        test_back_to_back();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
